sram_responder: RTL and testbench

Memory-side responder for the core's instruction and data SRAM ports. Serves both ports from one shared word-addressed RAM, with a fixed one-cycle read latency and byte-masked writes. Decodes a small MMIO window on the data port: LED, number display, switch input and a free-running timer. Sits outside `mycpu_core` in the SoC top, wired port-for-port to the core's `inst_sram_*` and `data_sram_*` signals.

---
 rtl/sram_responder_if.sv | 27 ++
 rtl/sram_responder.sv | 114 +++++++++++
 tb/tb_sram_responder.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_responder_if.sv
// Instruction and data SRAM port bundle between the core (master) and the memory responder (slave).
interface sram_responder_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rdata,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    output inst_sram_rdata,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/sram_responder.sv
// Shared word RAM serving the instruction and data ports with one-cycle registered reads,
// byte-masked writes and a data-port MMIO window (LED, number display, switches, timer).
module sram_responder #(
  parameter int unsigned ADDR_W  = 14,
  parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_responder_if.slave      bus,
  input  logic [7:0]           switch,
  output logic [15:0]          led,
  output logic [31:0]          num_data
);

  typedef enum logic [15:0] {
    MMIO_TIMER  = 16'hE000,
    MMIO_LED    = 16'hF000,
    MMIO_NUM    = 16'hF010,
    MMIO_SWITCH = 16'hF020
  } mmio_reg_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  logic [31:0] mem [0:(2**ADDR_W)-1];

  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic              d_wr, d_rd, d_mmio;
  logic [15:0]       d_off;
  logic [ADDR_W-1:0] d_idx, i_idx;
  logic [31:0]       mmio_rdata;
  logic              unused_bits;

  always_comb begin
    d_mmio = (bus.data_sram_addr[31:16] == MMIO_HI);
    d_off  = bus.data_sram_addr[15:0];
    d_wr   = bus.data_sram_en && (bus.data_sram_wen != '0);
    d_rd   = bus.data_sram_en && (bus.data_sram_wen == '0);
    d_idx  = bus.data_sram_addr[ADDR_W+1:2];
    i_idx  = bus.inst_sram_addr[ADDR_W+1:2];

    // MMIO reads see register values from before this edge, including the timer
    case (d_off)
      MMIO_LED:    mmio_rdata = {16'h0, led_q};
      MMIO_NUM:    mmio_rdata = num_q;
      MMIO_SWITCH: mmio_rdata = {24'h0, switch};
      MMIO_TIMER:  mmio_rdata = timer_q;
      default:     mmio_rdata = '0;
    endcase

    led_d   = led_q;
    num_d   = num_q;
    timer_d = timer_q + 32'd1;
    if (d_wr && d_mmio) begin
      case (d_off)
        MMIO_LED:   led_d   = 16'(byte_merge({16'h0, led_q}, bus.data_sram_wdata, bus.data_sram_wen));
        MMIO_NUM:   num_d   = byte_merge(num_q, bus.data_sram_wdata, bus.data_sram_wen);
        MMIO_TIMER: timer_d = byte_merge(timer_q, bus.data_sram_wdata, bus.data_sram_wen);
        default:    ;
      endcase
    end

    data_rdata_d = data_rdata_q;
    if (d_rd) data_rdata_d = d_mmio ? mmio_rdata : mem[d_idx];

    // Array read is of pre-edge contents, so a same-cycle data write is not visible here
    inst_rdata_d = inst_rdata_q;
    if (bus.inst_sram_en) inst_rdata_d = mem[i_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q        <= '0;
      num_q        <= '0;
      timer_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      led_q        <= led_d;
      num_q        <= num_d;
      timer_q      <= timer_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (d_wr && !d_mmio) begin
      for (int unsigned i = 0; i < 4; i++)
        if (bus.data_sram_wen[i]) mem[d_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
    end
  end

  assign bus.inst_sram_rdata = inst_rdata_q;
  assign bus.data_sram_rdata = data_rdata_q;
  assign led                 = led_q;
  assign num_data            = num_q;

  assign unused_bits = ^{bus.inst_sram_wen, bus.inst_sram_wdata,
                         bus.inst_sram_addr[31:ADDR_W+2], bus.inst_sram_addr[1:0]};

endmodule

// File: tb/tb_sram_responder.sv
// Directed and randomized checks of sram_responder against a behavioural memory/MMIO model.
module tb_sram_responder;
  localparam int unsigned AW  = 14;
  localparam logic [15:0] MHI = 16'hBFAF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  sw  = '0;
  logic [15:0] led;
  logic [31:0] num;

  sram_responder_if bus();

  sram_responder #(.ADDR_W(AW), .MMIO_HI(MHI)) dut (
    .clk(clk), .rst(rst), .bus(bus), .switch(sw), .led(led), .num_data(num)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem_m [int unsigned];
  logic [15:0] led_m;
  logic [31:0] num_m, timer_m, exp_d, exp_i;
  bit          d_known, i_known;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) % (32'd1 << AW);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv_d(input logic en, input logic [3:0] wen, input logic [31:0] a,
                       input logic [31:0] wd);
    bus.data_sram_en    = en;
    bus.data_sram_wen   = wen;
    bus.data_sram_addr  = a;
    bus.data_sram_wdata = wd;
  endtask

  task automatic drv_i(input logic en, input logic [31:0] a);
    bus.inst_sram_en    = en;
    bus.inst_sram_wen   = 4'($urandom);
    bus.inst_sram_addr  = a;
    bus.inst_sram_wdata = $urandom;
  endtask

  task automatic model_reset();
    led_m = '0; num_m = '0; timer_m = '0; exp_d = '0; exp_i = '0;
    d_known = 1'b1; i_known = 1'b1;
  endtask

  // One clock: apply the request present at the edge to the model, then compare.
  task automatic tick();
    logic [31:0] a, wd, t_new, tmp, old_v;
    logic [3:0]  be;
    bit          t_wr;
    int unsigned di, ii;
    @(posedge clk);
    a  = bus.data_sram_addr;  wd = bus.data_sram_wdata;  be = bus.data_sram_wen;
    di = widx(a);  ii = widx(bus.inst_sram_addr);
    t_wr = 1'b0;  t_new = '0;
    if (bus.inst_sram_en) begin
      i_known = mem_m.exists(ii);
      if (i_known) exp_i = mem_m[ii];
    end
    if (bus.data_sram_en) begin
      if (a[31:16] == MHI) begin
        if (be == 4'h0) begin
          d_known = 1'b1;
          case (a[15:0])
            16'hF000: exp_d = {16'h0, led_m};
            16'hF010: exp_d = num_m;
            16'hF020: exp_d = {24'h0, sw};
            16'hE000: exp_d = timer_m;
            default:  exp_d = 32'h0;
          endcase
        end else begin
          case (a[15:0])
            16'hF000: begin tmp = merge({16'h0, led_m}, wd, be); led_m = tmp[15:0]; end
            16'hF010: num_m = merge(num_m, wd, be);
            16'hE000: begin t_wr = 1'b1; t_new = merge(timer_m, wd, be); end
            default:  ;
          endcase
        end
      end else if (be == 4'h0) begin
        d_known = mem_m.exists(di);
        if (d_known) exp_d = mem_m[di];
      end else begin
        old_v = mem_m.exists(di) ? mem_m[di] : 32'hx;
        mem_m[di] = merge(old_v, wd, be);
      end
    end
    timer_m = t_wr ? t_new : timer_m + 32'd1;
    #1;
    if (d_known) check("data_rdata", bus.data_sram_rdata, exp_d);
    if (i_known) check("inst_rdata", bus.inst_sram_rdata, exp_i);
    check("led", {16'h0, led}, {16'h0, led_m});
    check("num_data", num, num_m);
  endtask

  function automatic logic [31:0] ram_addr(input int unsigned idx);
    logic [31:0] a;
    a = $urandom;
    a[AW+1:2] = AW'(idx);
    a[1:0] = 2'b00;
    if (a[31:16] == MHI) a[31] = ~a[31];
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] offs [6];
    logic [31:0] a;
    int unsigned op;
    offs = '{16'hF000, 16'hF010, 16'hF020, 16'hE000, 16'hF040, 16'h0000};

    // Reset held with random traffic
    drv_d(1'b0, 4'h0, 32'h0, 32'h0);
    drv_i(1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drv_d(1'($urandom), 4'($urandom), $urandom, $urandom);
      drv_i(1'($urandom), $urandom);
      sw = 8'($urandom);
    end
    check("rst_data_rdata", bus.data_sram_rdata, 32'h0);
    check("rst_inst_rdata", bus.inst_sram_rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_num", num, 32'h0);

    // Timer reads k-1 at the k-th edge after release
    @(negedge clk);
    drv_d(1'b1, 4'h0, {MHI, 16'hE000}, 32'h0);
    drv_i(1'b0, 32'h0);
    rst = 1'b1;
    model_reset();
    tick(); tick(); tick();
    check("timer_edge3", bus.data_sram_rdata, 32'd2);

    // Dual-port read-first on word 4
    drv_d(1'b1, 4'hF, 32'h8000_0010, 32'h0);
    tick();
    drv_d(1'b1, 4'hF, 32'h8000_0010, 32'hDEADBEEF);
    drv_i(1'b1, 32'h0000_0010);
    tick();
    check("dp_read_first", bus.inst_sram_rdata, 32'h0);
    drv_d(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    check("dp_next_read", bus.inst_sram_rdata, 32'hDEADBEEF);
    drv_i(1'b0, 32'h0);

    // Byte-masked RAM write
    drv_d(1'b1, 4'hF, 32'h8000_0010, 32'h11223344);     tick();
    drv_d(1'b1, 4'b0101, 32'h8000_0010, 32'hAABBCCDD);  tick();
    drv_d(1'b1, 4'h0, 32'h8000_0010, 32'h0);            tick();
    check("byte_merge", bus.data_sram_rdata, 32'h11BB33DD);

    // rdata holds across idle and write cycles
    drv_d(1'b0, 4'h0, 32'h8000_0010, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_idle", bus.data_sram_rdata, 32'h11BB33DD);
    end
    drv_d(1'b1, 4'hF, 32'h8000_0020, 32'h5555AAAA);
    tick();
    check("hold_write", bus.data_sram_rdata, 32'h11BB33DD);

    // MMIO registers
    drv_d(1'b1, 4'hF, {MHI, 16'hF000}, 32'hFFFF1234);   tick();
    check("led_write", {16'h0, led}, 32'h00001234);
    drv_d(1'b1, 4'h0, {MHI, 16'hF000}, 32'h0);          tick();
    check("led_read", bus.data_sram_rdata, 32'h00001234);
    drv_d(1'b1, 4'b1000, {MHI, 16'hF010}, 32'h7F000000); tick();
    check("num_write", num, 32'h7F000000);
    sw = 8'hA5;
    drv_d(1'b1, 4'h0, {MHI, 16'hF020}, 32'h0);          tick();
    check("switch_read", bus.data_sram_rdata, 32'h000000A5);
    drv_d(1'b1, 4'h0, {MHI, 16'hF040}, 32'h0);          tick();
    check("hole_read", bus.data_sram_rdata, 32'h0);

    // Timer load and wrap
    drv_d(1'b1, 4'hF, {MHI, 16'hE000}, 32'hFFFFFFFE);   tick();
    drv_d(1'b1, 4'h0, {MHI, 16'hE000}, 32'h0);
    tick(); check("timer_n1", bus.data_sram_rdata, 32'hFFFFFFFE);
    tick(); check("timer_n2", bus.data_sram_rdata, 32'hFFFFFFFF);
    tick(); check("timer_n3", bus.data_sram_rdata, 32'h00000000);

    // Preload a small RAM region, then randomized mixed traffic
    for (int i = 0; i < 16; i++) begin
      drv_d(1'b1, 4'hF, ram_addr(i), $urandom);
      tick();
    end
    for (int n = 0; n < 400; n++) begin
      sw = 8'($urandom);
      op = $urandom_range(0, 4);
      case (op)
        0: drv_d(1'b0, 4'($urandom), $urandom, $urandom);
        1: drv_d(1'b1, 4'($urandom_range(1, 15)), ram_addr($urandom_range(0, 15)), $urandom);
        2: drv_d(1'b1, 4'h0, ram_addr($urandom_range(0, 15)), $urandom);
        3: drv_d(1'b1, 4'($urandom_range(1, 15)), {MHI, offs[$urandom_range(0, 5)]}, $urandom);
        default: drv_d(1'b1, 4'h0, {MHI, offs[$urandom_range(0, 5)]}, $urandom);
      endcase
      a = $urandom;
      a[AW+1:2] = AW'($urandom_range(0, 15));
      drv_i(1'($urandom), a);
      tick();
    end

    // Reset asserted while a read is pending
    drv_d(1'b1, 4'h0, ram_addr(1), 32'h0);
    drv_i(1'b1, ram_addr(2));
    #2 rst = 1'b0;
    #1;
    check("midrst_data", bus.data_sram_rdata, 32'h0);
    check("midrst_inst", bus.inst_sram_rdata, 32'h0);
    check("midrst_led", {16'h0, led}, 32'h0);
    check("midrst_num", num, 32'h0);
    @(negedge clk);
    drv_d(1'b1, 4'h0, {MHI, 16'hE000}, 32'h0);
    drv_i(1'b1, ram_addr(2));
    rst = 1'b1;
    model_reset();
    tick();
    check("postrst_timer", bus.data_sram_rdata, 32'h0);
    drv_d(1'b1, 4'h0, ram_addr(1), 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
